// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
//   state_e   : loader FSM state encoding
//   byte_slot : maps the arrival index of a byte to its byte lane in a word
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERROR   = 2'd3
    } state_e;

    localparam int unsigned TERM_RUN_W = 4;

    // Byte lane for the idx-th byte of a word; big-endian fills from the top lane down.
    function automatic int unsigned byte_slot(input int unsigned idx,
                                              input int unsigned nbytes,
                                              input logic        big_endian);
        return big_endian ? (nbytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle timer.
//   clk, resetn : clock and asynchronous active-low reset
//   enable      : count only while a partial word is pending
//   kick        : byte activity, restarts the count
//   expire      : one-cycle pulse, registered, after LIMIT consecutive idle enabled cycles
module idle_timer #(
    parameter int unsigned LIMIT = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    input  logic kick,
    output logic expire
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_q, expire_d;

    // Count idle cycles; fire and restart when the LIMIT-th idle cycle is seen.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (!enable || kick) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(LIMIT - 1)) begin
            expire_d = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Assembles UART bytes into words and streams them into instruction memory,
// releasing the CPU reset once a run of terminator words has been written.
//   clk, resetn          : clock, asynchronous active-low reset
//   rx_valid/rx_data     : received byte strobe and value
//   rx_break             : BREAK strobe, restarts a running load
//   load_en              : level, arms and holds a load
//   mem_we/addr/wdata    : registered one-cycle memory write
//   word_count           : words written in the current load
//   write_done           : load completed (terminator run seen)
//   load_error           : sticky overflow flag
//   core_resetn          : CPU reset, released only while write_done is high
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned        DATA_W      = 32,
    parameter int unsigned        DEPTH       = 256,
    parameter int unsigned        BIG_ENDIAN  = 0,
    parameter logic [DATA_W-1:0]  TERM_WORD   = '1,
    parameter int unsigned        TERM_COUNT  = 2,
    parameter int unsigned        TIMEOUT_CYC = 0,
    localparam int unsigned       ADDR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_break,
    input  logic              load_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              write_done,
    output logic              load_error,
    output logic              core_resetn
);

    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    state_e                  state_q, state_d;
    logic [BIDX_W-1:0]       byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]       word_q, word_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]        word_count_q, word_count_d;
    logic [TERM_RUN_W-1:0]   term_run_q, term_run_d;
    logic                    write_done_q, write_done_d;
    logic                    load_error_q, load_error_d;
    logic                    core_resetn_q, core_resetn_d;

    logic [BIDX_W-1:0]       cur_idx;
    int unsigned             slot;
    logic [DATA_W-1:0]       asm_word;
    logic [TERM_RUN_W-1:0]   term_inc;
    logic                    timer_en, timer_kick, timer_expire;

    // A pending partial word is only timed while collecting.
    assign timer_en   = (state_q == ST_COLLECT) && (byte_idx_q != '0);
    assign timer_kick = rx_valid;

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            idle_timer #(
                .LIMIT (TIMEOUT_CYC)
            ) u_idle_timer (
                .clk    (clk),
                .resetn (resetn),
                .enable (timer_en),
                .kick   (timer_kick),
                .expire (timer_expire)
            );
        end else begin : g_no_timer
            logic unused_timer;
            assign timer_expire = 1'b0;
            assign unused_timer = ^{timer_en, timer_kick};
        end
    endgenerate

    // Word assembly; an expiring partial word is dropped so a byte arriving now starts fresh.
    always_comb begin
        cur_idx  = timer_expire ? '0 : byte_idx_q;
        slot     = byte_slot(32'(cur_idx), NBYTES, BIG_ENDIAN != 0);
        asm_word = word_q;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (slot == b) begin
                asm_word[8*b +: 8] = rx_data;
            end
        end
        term_inc = term_run_q + 1'b1;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        term_run_d   = term_run_q;

        unique case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d      = ST_COLLECT;
                    byte_idx_d   = '0;
                    term_run_d   = '0;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                end
            end
            ST_COLLECT: begin
                if (!load_en) begin
                    state_d = ST_IDLE;
                end else if (rx_break) begin
                    byte_idx_d   = '0;
                    term_run_d   = '0;
                    word_count_d = '0;
                    mem_addr_d   = '0;
                end else if (rx_valid) begin
                    word_d = asm_word;
                    if (cur_idx == BIDX_W'(NBYTES - 1)) begin
                        byte_idx_d = '0;
                        // word_count doubles as the next write address.
                        if (word_count_q == CNT_W'(DEPTH)) begin
                            state_d = ST_ERROR;
                        end else begin
                            mem_we_d     = 1'b1;
                            mem_addr_d   = word_count_q[ADDR_W-1:0];
                            mem_wdata_d  = asm_word;
                            word_count_d = word_count_q + 1'b1;
                            if (asm_word == TERM_WORD) begin
                                term_run_d = term_inc;
                                if (term_inc == TERM_RUN_W'(TERM_COUNT)) begin
                                    state_d = ST_DONE;
                                end
                            end else begin
                                term_run_d = '0;
                            end
                        end
                    end else begin
                        byte_idx_d = cur_idx + 1'b1;
                    end
                end else if (timer_expire) begin
                    byte_idx_d = '0;
                end
            end
            ST_DONE, ST_ERROR: begin
                if (!load_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        write_done_d  = (state_d == ST_DONE);
        core_resetn_d = (state_d == ST_DONE);
        load_error_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            byte_idx_q    <= '0;
            word_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            word_count_q  <= '0;
            term_run_q    <= '0;
            write_done_q  <= 1'b0;
            load_error_q  <= 1'b0;
            core_resetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            word_q        <= word_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            word_count_q  <= word_count_d;
            term_run_q    <= term_run_d;
            write_done_q  <= write_done_d;
            load_error_q  <= load_error_d;
            core_resetn_q <= core_resetn_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign word_count  = word_count_q;
    assign write_done  = write_done_q;
    assign load_error  = load_error_q;
    assign core_resetn = core_resetn_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: four instances (defaults, DEPTH=4, TIMEOUT_CYC=100,
// BIG_ENDIAN=1) share the byte stream; each is armed by its own load_en bit.
module tb_uart_imem_loader;
    import loader_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        done;
    } wr_t;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       rx_valid = 1'b0;
    logic       rx_break = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [3:0] le = 4'h0;

    logic we_def, done_def, err_def, crst_def;
    logic [7:0] addr_def; logic [31:0] wd_def; logic [8:0] wc_def;
    logic we_dep, done_dep, err_dep, crst_dep;
    logic [1:0] addr_dep; logic [31:0] wd_dep; logic [2:0] wc_dep;
    logic we_tmo, done_tmo, err_tmo, crst_tmo;
    logic [7:0] addr_tmo; logic [31:0] wd_tmo; logic [8:0] wc_tmo;
    logic we_be, done_be, err_be, crst_be;
    logic [7:0] addr_be; logic [31:0] wd_be; logic [8:0] wc_be;

    wr_t         q_def[$], q_dep[$], q_tmo[$], q_be[$];
    logic [7:0]  sent[$];
    logic [31:0] exp_q[$];
    int          exp_a[$];
    bit          exp_done, exp_err;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    uart_imem_loader u_def (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .load_en(le[0]), .mem_we(we_def), .mem_addr(addr_def),
        .mem_wdata(wd_def), .word_count(wc_def), .write_done(done_def),
        .load_error(err_def), .core_resetn(crst_def));

    uart_imem_loader #(.DEPTH(4)) u_dep (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .load_en(le[1]), .mem_we(we_dep), .mem_addr(addr_dep),
        .mem_wdata(wd_dep), .word_count(wc_dep), .write_done(done_dep),
        .load_error(err_dep), .core_resetn(crst_dep));

    uart_imem_loader #(.TIMEOUT_CYC(100)) u_tmo (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .load_en(le[2]), .mem_we(we_tmo), .mem_addr(addr_tmo),
        .mem_wdata(wd_tmo), .word_count(wc_tmo), .write_done(done_tmo),
        .load_error(err_tmo), .core_resetn(crst_tmo));

    uart_imem_loader #(.BIG_ENDIAN(1)) u_be (
        .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_break(rx_break), .load_en(le[3]), .mem_we(we_be), .mem_addr(addr_be),
        .mem_wdata(wd_be), .word_count(wc_be), .write_done(done_be),
        .load_error(err_be), .core_resetn(crst_be));

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (we_def) q_def.push_back('{addr: addr_def,     data: wd_def, done: done_def});
        if (we_dep) q_dep.push_back('{addr: 8'(addr_dep), data: wd_dep, done: done_dep});
        if (we_tmo) q_tmo.push_back('{addr: addr_tmo,     data: wd_tmo, done: done_tmo});
        if (we_be)  q_be.push_back('{addr: addr_be,       data: wd_be,  done: done_be});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        sent.push_back(b);
    endtask

    task automatic clear_all();
        sent.delete(); exp_q.delete(); exp_a.delete();
        q_def.delete(); q_dep.delete(); q_tmo.delete(); q_be.delete();
        exp_done = 1'b0; exp_err = 1'b0;
    endtask

    task automatic disarm();
        le = 4'h0;
        idle(2);
    endtask

    // Reference: bytes grouped in fours, written in order until the memory is full
    // (error) or two consecutive all-ones words have been written (done).
    task automatic build_expect(input bit be, input int depth);
        int run;
        logic [31:0] w;
        run = 0;
        exp_q.delete(); exp_a.delete(); exp_done = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < sent.size() / 4; i++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (be) w = (w << 8) | 32'(sent[4*i+k]);
                else    w = w | (32'(sent[4*i+k]) << (8*k));
            end
            if (exp_q.size() == depth) begin exp_err = 1'b1; break; end
            exp_a.push_back(exp_q.size());
            exp_q.push_back(w);
            run = (w == 32'hFFFF_FFFF) ? run + 1 : 0;
            if (run == 2) begin exp_done = 1'b1; break; end
        end
    endtask

    task automatic send_rand_word(output logic [7:0] b0, output logic [7:0] b1,
                                  output logic [7:0] b2, output logic [7:0] b3);
        b0 = 8'($urandom_range(0, 254));
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        n_vec++;
        if ({we_def, addr_def, wd_def, wc_def, done_def, err_def, crst_def} !== '0) begin
            n_err++; $display("FAIL reset_def: outputs not at reset values, wdata=%h wc=%0d", wd_def, wc_def);
        end
        n_vec++;
        if ({we_dep, addr_dep, wd_dep, wc_dep, done_dep, err_dep, crst_dep} !== '0) begin
            n_err++; $display("FAIL reset_dep: outputs not at reset values");
        end
        n_vec++;
        if ({we_tmo, addr_tmo, wd_tmo, wc_tmo, done_tmo, err_tmo, crst_tmo} !== '0) begin
            n_err++; $display("FAIL reset_tmo: outputs not at reset values");
        end
        n_vec++;
        if ({we_be, addr_be, wd_be, wc_be, done_be, err_be, crst_be} !== '0) begin
            n_err++; $display("FAIL reset_be: outputs not at reset values");
        end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({crst_def, crst_dep, crst_tmo, crst_be} !== 4'b0000) begin
            n_err++; $display("FAIL reset_release: core_resetn=%b expected 0000",
                              {crst_def, crst_dep, crst_tmo, crst_be});
        end
    endtask

    task automatic test_idle_ignore();
        clear_all();
        for (int k = 0; k < 8; k++) send_byte(8'($urandom));
        idle(3);
        n_vec++;
        if (q_def.size() + q_dep.size() + q_tmo.size() + q_be.size() !== 0) begin
            n_err++; $display("FAIL idle_ignore: got %0d writes while unarmed, expected 0",
                              q_def.size() + q_dep.size() + q_tmo.size() + q_be.size());
        end
    endtask

    task automatic test_single_word();
        clear_all();
        le[0] = 1'b1; idle(1);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFB);
        idle(3);
        n_vec++;
        if (q_def.size() !== 1) begin
            n_err++; $display("FAIL single_count: got %0d writes, expected 1", q_def.size());
        end else begin
            n_vec++;
            if (q_def[0].addr !== 8'd0 || q_def[0].data !== 32'hFB01_0113) begin
                n_err++; $display("FAIL single_write: got addr %0d data %h, expected addr 0 data fb010113",
                                  q_def[0].addr, q_def[0].data);
            end
        end
        n_vec++;
        if (wc_def !== 9'd1 || done_def !== 1'b0) begin
            n_err++; $display("FAIL single_status: wc=%0d done=%b, expected wc=1 done=0", wc_def, done_def);
        end
        disarm();
    endtask

    task automatic test_program();
        int nprog, lone_pos;
        logic [7:0] b;
        state_e exp_st, obs_st;
        for (int it = 0; it < 4; it++) begin
            clear_all();
            le[0] = 1'b1; idle(1);
            nprog    = (it == 0) ? 3 : int'($urandom_range(1, 6));
            lone_pos = (it == 0) ? -1 : int'($urandom_range(0, nprog - 1));
            for (int w = 0; w < nprog; w++) begin
                if (w == lone_pos) for (int k = 0; k < 4; k++) send_byte(8'hFF);
                for (int k = 0; k < 4; k++) begin
                    b = 8'($urandom);
                    if (k == 0 && b == 8'hFF) b = 8'h00;
                    send_byte(b);
                    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
                end
            end
            for (int k = 0; k < 8; k++) send_byte(8'hFF);
            for (int k = 0; k < 8; k++) send_byte(8'($urandom));
            idle(3);
            build_expect(1'b0, 256);
            n_vec++;
            if (q_def.size() !== exp_q.size()) begin
                n_err++; $display("FAIL prog_count it=%0d: got %0d writes, expected %0d",
                                  it, q_def.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < q_def.size(); i++) begin
                n_vec++;
                if (q_def[i].data !== exp_q[i] || q_def[i].addr !== 8'(exp_a[i]) ||
                    q_def[i].done !== 1'(i == exp_q.size() - 1)) begin
                    n_err++; $display("FAIL prog_write it=%0d #%0d: got addr %0d data %h done %b, expected addr %0d data %h done %b",
                                      it, i, q_def[i].addr, q_def[i].data, q_def[i].done,
                                      exp_a[i], exp_q[i], (i == exp_q.size() - 1));
                end
            end
            exp_st = exp_done ? ST_DONE : ST_COLLECT;
            obs_st = err_def ? ST_ERROR : (done_def ? ST_DONE : ST_COLLECT);
            n_vec++;
            if (obs_st !== exp_st || crst_def !== 1'(exp_done) || wc_def !== 9'(exp_q.size())) begin
                n_err++; $display("FAIL prog_status it=%0d: got %s core_resetn=%b wc=%0d, expected %s core_resetn=%b wc=%0d",
                                  it, obs_st.name(), crst_def, wc_def, exp_st.name(), exp_done, exp_q.size());
            end
            disarm();
            n_vec++;
            if ({done_def, crst_def} !== 2'b00) begin
                n_err++; $display("FAIL prog_disarm it=%0d: done=%b core_resetn=%b, expected 0 0",
                                  it, done_def, crst_def);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b0, b1, b2, b3;
        state_e obs_st;
        clear_all();
        le[1] = 1'b1; idle(1);
        for (int w = 0; w < 5; w++) send_rand_word(b0, b1, b2, b3);
        idle(3);
        build_expect(1'b0, 4);
        n_vec++;
        if (q_dep.size() !== exp_q.size()) begin
            n_err++; $display("FAIL ovf_count: got %0d writes, expected %0d", q_dep.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_dep.size(); i++) begin
            n_vec++;
            if (q_dep[i].data !== exp_q[i] || q_dep[i].addr !== 8'(exp_a[i])) begin
                n_err++; $display("FAIL ovf_write #%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, q_dep[i].addr, q_dep[i].data, exp_a[i], exp_q[i]);
            end
        end
        obs_st = err_dep ? ST_ERROR : (done_dep ? ST_DONE : ST_COLLECT);
        n_vec++;
        if (obs_st !== ST_ERROR || done_dep !== 1'b0 || wc_dep !== 3'd4 || !exp_err) begin
            n_err++; $display("FAIL ovf_status: got %s done=%b wc=%0d, expected ST_ERROR done=0 wc=4",
                              obs_st.name(), done_dep, wc_dep);
        end
        send_rand_word(b0, b1, b2, b3);
        idle(3);
        n_vec++;
        if (q_dep.size() !== 4) begin
            n_err++; $display("FAIL ovf_locked: got %0d writes, expected 4", q_dep.size());
        end
        disarm();
        n_vec++;
        if (err_dep !== 1'b0) begin
            n_err++; $display("FAIL ovf_disarm: load_error=%b expected 0", err_dep);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] r0, r1, r2, r3;
        clear_all();
        le[2] = 1'b1; idle(1);
        // Partial word abandoned by a long gap.
        send_byte(8'hAA); send_byte(8'hBB); idle(150);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h01); send_byte(8'hFB);
        exp_q.push_back(32'hFB01_0113);
        // Gap well below the limit keeps the partial word.
        send_byte(8'hAA); send_byte(8'hBB); idle(50);
        send_byte(8'hCC); send_byte(8'hDD);
        exp_q.push_back(32'hDDCC_BBAA);
        // Exactly the limit: partial discarded.
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        idle(100);
        send_rand_word(r0, r1, r2, r3);
        exp_q.push_back({r3, r2, r1, r0});
        // One short of the limit: partial kept.
        r0 = 8'($urandom_range(0, 254)); r1 = 8'($urandom);
        send_byte(r0); send_byte(r1); idle(99);
        r2 = 8'($urandom); r3 = 8'($urandom);
        send_byte(r2); send_byte(r3);
        exp_q.push_back({r3, r2, r1, r0});
        idle(3);
        n_vec++;
        if (q_tmo.size() !== exp_q.size()) begin
            n_err++; $display("FAIL tmo_count: got %0d writes, expected %0d", q_tmo.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_tmo.size(); i++) begin
            n_vec++;
            if (q_tmo[i].data !== exp_q[i] || q_tmo[i].addr !== 8'(i)) begin
                n_err++; $display("FAIL tmo_write #%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, q_tmo[i].addr, q_tmo[i].data, i, exp_q[i]);
            end
        end
        n_vec++;
        if (wc_tmo !== 9'd4 || err_tmo !== 1'b0) begin
            n_err++; $display("FAIL tmo_status: wc=%0d err=%b, expected wc=4 err=0", wc_tmo, err_tmo);
        end
        disarm();
    endtask

    task automatic test_big_endian_break();
        logic [7:0] b0, b1, b2, b3;
        clear_all();
        le[3] = 1'b1; idle(1);
        send_byte(8'hFB); send_byte(8'h01); send_byte(8'h01); send_byte(8'h13);
        exp_q.push_back(32'hFB01_0113); exp_a.push_back(0);
        send_rand_word(b0, b1, b2, b3);
        exp_q.push_back({b0, b1, b2, b3}); exp_a.push_back(1);
        send_byte(8'($urandom)); send_byte(8'($urandom));
        // BREAK together with a valid byte: the break must win.
        rx_break = 1'b1; rx_valid = 1'b1; rx_data = 8'h5A;
        @(posedge clk); #1;
        rx_break = 1'b0; rx_valid = 1'b0;
        send_rand_word(b0, b1, b2, b3);
        exp_q.push_back({b0, b1, b2, b3}); exp_a.push_back(0);
        idle(3);
        n_vec++;
        if (q_be.size() !== exp_q.size()) begin
            n_err++; $display("FAIL be_count: got %0d writes, expected %0d", q_be.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < q_be.size(); i++) begin
            n_vec++;
            if (q_be[i].data !== exp_q[i] || q_be[i].addr !== 8'(exp_a[i])) begin
                n_err++; $display("FAIL be_write #%0d: got addr %0d data %h, expected addr %0d data %h",
                                  i, q_be[i].addr, q_be[i].data, exp_a[i], exp_q[i]);
            end
        end
        n_vec++;
        if (wc_be !== 9'd1) begin
            n_err++; $display("FAIL be_count_after_break: word_count=%0d expected 1", wc_be);
        end
        disarm();
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] b0, b1, b2, b3;
        clear_all();
        le[0] = 1'b1; idle(1);
        send_rand_word(b0, b1, b2, b3);
        send_byte(8'($urandom)); send_byte(8'($urandom));
        n_vec++;
        if (wc_def !== 9'd1) begin
            n_err++; $display("FAIL rst_pre: word_count=%0d expected 1", wc_def);
        end
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({we_def, addr_def, wd_def, wc_def, done_def, err_def, crst_def} !== '0) begin
            n_err++; $display("FAIL rst_async: wdata=%h wc=%0d we=%b, expected all zero",
                              wd_def, wc_def, we_def);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        q_def.delete();
        send_rand_word(b0, b1, b2, b3);
        idle(3);
        n_vec++;
        if (q_def.size() !== 1) begin
            n_err++; $display("FAIL rst_rearm_count: got %0d writes, expected 1", q_def.size());
        end else begin
            n_vec++;
            if (q_def[0].addr !== 8'd0 || q_def[0].data !== {b3, b2, b1, b0}) begin
                n_err++; $display("FAIL rst_rearm_write: got addr %0d data %h, expected addr 0 data %h",
                                  q_def[0].addr, q_def[0].data, {b3, b2, b1, b0});
            end
        end
        n_vec++;
        if (wc_def !== 9'd1) begin
            n_err++; $display("FAIL rst_rearm_wc: word_count=%0d expected 1", wc_def);
        end
        disarm();
    endtask

    initial begin
        #1;
        test_reset();
        test_idle_ignore();
        test_single_word();
        test_program();
        test_overflow();
        test_timeout();
        test_big_endian_break();
        test_reset_mid_word();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
